// File: rtl/user_code_loadable_mem.sv
// Runtime-loadable instruction store for the i281 CPU: DEPTH x WIDTH registers, streamed load port, combinational fetch port.
// Optional running checksum of loaded words is enabled by defining USER_CODE_CHECKSUM_EN.
module user_code_loadable_mem #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             ld_start,
    input  logic             ld_valid,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_end,
    output logic             ld_ready,
    output logic             ld_busy,
    output logic             ld_done,
    output logic [AW:0]      ld_count,
    output logic             cpu_hold,
    output logic [WIDTH-1:0] ld_checksum
);

    // Handshake: a word transfers on a rising edge where ld_valid && ld_ready;
    // ld_ready is high for the whole LOAD state and never depends on ld_valid.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FILL = 2'd2
    } state_t;

    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

    state_t           r_state;
    logic [AW-1:0]    r_ptr;
    logic [AW:0]      r_count;
    logic             r_done;
    logic [WIDTH-1:0] r_mem [DEPTH];

    state_t           w_state_nxt;
    logic [AW-1:0]    w_ptr_nxt;
    logic [AW:0]      w_count_nxt;
    logic             w_done_nxt;
    logic             w_wr_en;
    logic [WIDTH-1:0] w_wr_data;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_data   = '0;
        case (r_state)
            S_IDLE: begin
                if (ld_start) begin
                    w_state_nxt = S_LOAD;
                    w_ptr_nxt   = '0;
                    w_count_nxt = '0;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    w_wr_en     = 1'b1;
                    w_wr_data   = ld_data;
                    w_count_nxt = r_count + CNT_ONE;
                    // The last address completes the session even if ld_end is also high.
                    if (r_ptr == PTR_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_ptr_nxt = r_ptr + PTR_ONE;
                        if (ld_end) begin
                            w_state_nxt = S_FILL;
                        end
                    end
                end else if (ld_end) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                w_wr_en = 1'b1;
                if (r_ptr == PTR_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_ptr_nxt = r_ptr + PTR_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr   <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ptr   <= w_ptr_nxt;
            r_count <= w_count_nxt;
            r_done  <= w_done_nxt;
            if (w_wr_en) begin
                r_mem[r_ptr] <= w_wr_data;
            end
        end
    end

`ifdef USER_CODE_CHECKSUM_EN
    logic [WIDTH-1:0] r_checksum;
    logic             w_sum_clear;
    logic             w_sum_add;

    assign w_sum_clear = (r_state == S_IDLE) && ld_start;
    assign w_sum_add   = (r_state == S_LOAD) && ld_valid;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_checksum <= '0;
        end else if (w_sum_clear) begin
            r_checksum <= '0;
        end else if (w_sum_add) begin
            r_checksum <= r_checksum + ld_data;
        end
    end

    assign ld_checksum = r_checksum;
`else
    assign ld_checksum = '0;
`endif

    // The CPU sees NOOPs (all zeros) whenever a session owns the memory.
    assign ld_busy  = (r_state != S_IDLE);
    assign cpu_hold = ld_busy;
    assign ld_ready = (r_state == S_LOAD);
    assign ld_done  = r_done;
    assign ld_count = r_count;
    assign rd_data  = ld_busy ? '0 : r_mem[rd_addr];

endmodule

// File: tb/tb_user_code_loadable_mem.sv
// Self-checking bench for user_code_loadable_mem: table of load sessions, randomized sessions, reset corner cases.
// Expected checksum follows USER_CODE_CHECKSUM_EN when the bench is built with the same define.
module tb_user_code_loadable_mem;

    localparam int WIDTH = 16;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);

    logic             Clock;
    logic             Reset_n;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             ld_start;
    logic             ld_valid;
    logic [WIDTH-1:0] ld_data;
    logic             ld_end;
    logic             ld_ready;
    logic             ld_busy;
    logic             ld_done;
    logic [AW:0]      ld_count;
    logic             cpu_hold;
    logic [WIDTH-1:0] ld_checksum;

    user_code_loadable_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .ld_start    (ld_start),
        .ld_valid    (ld_valid),
        .ld_data     (ld_data),
        .ld_end      (ld_end),
        .ld_ready    (ld_ready),
        .ld_busy     (ld_busy),
        .ld_done     (ld_done),
        .ld_count    (ld_count),
        .cpu_hold    (cpu_hold),
        .ld_checksum (ld_checksum)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        int n;
        bit combined;
        int gap_max;
        bit noise;
        int exp_count;
        int exp_fill;
    } vec_t;

    int               checks = 0;
    int               errors = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] pat[DEPTH];
    vec_t             vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        ld_end   = 1'b0;
        ld_data  = WIDTH'($urandom);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic readback_all(input string name);
        logic [WIDTH-1:0] e;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = AW'(a);
            #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            check(name, rd_data, e);
        end
    endtask

    task automatic run_session(input int n, input bit combined, input int gap_max, input bit noise,
                               input bit use_pat, input int exp_count, input int exp_fill);
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] sum;
        int k;
        int gaps;
        sum = '0;
        exp_q.delete();
        idle_inputs();
        ld_start = 1'b1;
        rd_addr  = AW'($urandom);
        tick();
        idle_inputs();
        check("start_busy", ld_busy, 1);
        check("start_ready", ld_ready, 1);
        check("start_count", ld_count, 0);
        check("start_checksum", ld_checksum, 0);
        check("load_rd_zero", rd_data, 0);
        for (int i = 0; i < n; i++) begin
            gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
            for (int g = 0; g < gaps; g++) begin
                idle_inputs();
                if (noise) ld_start = 1'($urandom_range(0, 1));
                rd_addr = AW'($urandom);
                tick();
                check("gap_hold", cpu_hold, 1);
                check("gap_rd_zero", rd_data, 0);
                check("gap_count", ld_count, i);
            end
            w = use_pat ? pat[i] : WIDTH'($urandom);
            exp_q.push_back(w);
            sum += w;
            ld_valid = 1'b1;
            ld_data  = w;
            ld_end   = combined && (i == n - 1);
            ld_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            idle_inputs();
            if (i == DEPTH - 1) begin
                check("last_word_done", ld_done, 1);
                check("last_word_busy", ld_busy, 0);
            end else begin
                check("word_busy", ld_busy, 1);
                check("word_done", ld_done, 0);
                check("word_count", ld_count, i + 1);
            end
        end
        k = 0;
        if (n < DEPTH) begin
            if (!(combined && n > 0)) begin
                ld_end = 1'b1;
                tick();
                idle_inputs();
            end
            while (ld_busy && k < 2 * DEPTH) begin
                check("fill_ready", ld_ready, 0);
                check("fill_done", ld_done, 0);
                check("fill_rd_zero", rd_data, 0);
                if (noise) begin
                    ld_valid = 1'($urandom_range(0, 1));
                    ld_end   = 1'($urandom_range(0, 1));
                    ld_start = 1'($urandom_range(0, 1));
                end
                tick();
                idle_inputs();
                k++;
            end
            check("end_done", ld_done, 1);
        end
        check("fill_cycles", k, exp_fill);
        check("end_busy", ld_busy, 0);
        tick();
        check("done_one_cycle", ld_done, 0);
        check("final_count", ld_count, exp_count);
`ifdef USER_CODE_CHECKSUM_EN
        check("checksum", ld_checksum, sum);
`else
        check("checksum", ld_checksum, 0);
`endif
        readback_all("readback");
    endtask

    initial begin
        pat[0] = 16'hE0F4;
        pat[1] = 16'h5001;
        pat[2] = 16'hE0EE;
        pat[3] = 16'h7A03;
        pat[4] = 16'h1234;
        for (int i = 5; i < DEPTH; i++) pat[i] = WIDTH'(16'h1000 + i * 16'h0101);

        vecs[0] = '{32, 1'b0, 0, 1'b0, 32, 0};
        vecs[1] = '{3,  1'b0, 0, 1'b0, 3,  29};
        vecs[2] = '{5,  1'b1, 0, 1'b0, 5,  27};
        vecs[3] = '{0,  1'b0, 0, 1'b1, 0,  32};
        vecs[4] = '{31, 1'b1, 2, 1'b1, 31, 1};
        vecs[5] = '{32, 1'b1, 1, 1'b1, 32, 0};
        vecs[6] = '{1,  1'b1, 0, 1'b0, 1,  31};

        Reset_n = 1'b0;
        rd_addr = '0;
        idle_inputs();
        repeat (3) @(posedge Clock);
        #1;
        check("rst_busy", ld_busy, 0);
        check("rst_done", ld_done, 0);
        check("rst_ready", ld_ready, 0);
        check("rst_hold", cpu_hold, 0);
        check("rst_count", ld_count, 0);
        check("rst_checksum", ld_checksum, 0);
        Reset_n = 1'b1;
        tick();
        exp_q.delete();
        readback_all("rst_readback");

        // Inputs other than ld_start are ignored in IDLE.
        ld_valid = 1'b1;
        ld_end   = 1'b1;
        tick();
        idle_inputs();
        check("idle_ignore_busy", ld_busy, 0);
        check("idle_ignore_count", ld_count, 0);

        for (int v = 0; v < 7; v++) begin
            run_session(vecs[v].n, vecs[v].combined, vecs[v].gap_max, vecs[v].noise, 1'b1,
                        vecs[v].exp_count, vecs[v].exp_fill);
        end

        for (int r = 0; r < 12; r++) begin
            int n;
            n = $urandom_range(0, DEPTH);
            run_session(n, 1'($urandom_range(0, 1)), 2, 1'b1, 1'b0, n, DEPTH - n);
        end

        // Asynchronous reset while filling at address 10.
        idle_inputs();
        ld_start = 1'b1;
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1'b1;
            ld_data  = pat[i];
            tick();
            idle_inputs();
        end
        ld_end = 1'b1;
        tick();
        idle_inputs();
        check("pre_reset_fill_busy", ld_busy, 1);
        check("pre_reset_ready", ld_ready, 0);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_rst_busy", ld_busy, 0);
        check("async_rst_hold", cpu_hold, 0);
        check("async_rst_ready", ld_ready, 0);
        check("async_rst_done", ld_done, 0);
        check("async_rst_count", ld_count, 0);
        check("async_rst_checksum", ld_checksum, 0);
        exp_q.delete();
        readback_all("async_rst_readback");
        tick();
        Reset_n = 1'b1;
        tick();
        run_session(2, 1'b0, 0, 1'b0, 1'b1, 2, 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
